// File: rtl/firewall_filter.sv
`default_nettype none
// ============================================================================
// firewall_filter - buffers packet words and per-packet actions, then forwards
// or silently discards each whole packet in arrival order.
// Optional statistics: FIREWALL_FILTER_CNT_EN builds pass_cnt / drop_cnt.
// Revision: 1.0
// ============================================================================
module firewall_filter #(
  parameter int W_PKT      = 134,
  parameter int D_PKTBUF   = 8,
  parameter int D_ACTBUF   = 4,
  parameter int PKT_THRESH = 160
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pktin_data_wr,
  input  logic [W_PKT-1:0] pktin_data,
  output logic             pktin_ready,
  input  logic             action_valid,
  input  logic             action,
  output logic             pktout_data_wr,
  output logic [W_PKT-1:0] pktout_data,
  input  logic             pktout_ready,
  output logic [31:0]      pass_cnt,
  output logic [31:0]      drop_cnt,
  output logic             act_ovf
);

  localparam int                c_PDEPTH = 1 << D_PKTBUF;
  localparam int                c_ADEPTH = 1 << D_ACTBUF;
  localparam logic [D_PKTBUF:0] c_PFULL  = (D_PKTBUF+1)'(c_PDEPTH);
  localparam logic [D_ACTBUF:0] c_AFULL  = (D_ACTBUF+1)'(c_ADEPTH);
  localparam logic [D_PKTBUF:0] c_THRESH = (D_PKTBUF+1)'(PKT_THRESH);

  typedef enum logic [1:0] {IDLE_S, DECIDE_S, FORWARD_S, DISCARD_S} state_t;

  logic [W_PKT-1:0]    r_pmem [c_PDEPTH];
  logic [D_PKTBUF-1:0] r_pwr, r_prd;
  logic [D_PKTBUF:0]   r_pcnt;
  logic                r_amem [c_ADEPTH];
  logic [D_ACTBUF-1:0] r_awr, r_ard;
  logic [D_ACTBUF:0]   r_acnt;

  state_t              r_state;
  logic [W_PKT-1:0]    r_word;
  logic                r_wvld;
  logic                r_act;
  logic                r_pktout_wr;
  logic [W_PKT-1:0]    r_pktout_data;
  logic                r_pktin_ready;
  logic                r_act_ovf;

  logic                w_pempty, w_pfull, w_aempty, w_afull;
  logic                w_ppush, w_ppop, w_apush, w_apop, w_tail;
  logic [D_PKTBUF:0]   w_pcnt_nxt;

  assign w_pempty   = (r_pcnt == '0);
  assign w_pfull    = (r_pcnt == c_PFULL);
  assign w_aempty   = (r_acnt == '0);
  assign w_afull    = (r_acnt == c_AFULL);
  assign w_tail     = (r_word[W_PKT-1:W_PKT-2] == 2'b10);
  // A pop frees a slot in the same cycle, so a push to a full FIFO still lands.
  assign w_ppush    = pktin_data_wr && (!w_pfull || w_ppop);
  assign w_apush    = action_valid  && (!w_afull || w_apop);
  assign w_pcnt_nxt = r_pcnt + (D_PKTBUF+1)'(w_ppush) - (D_PKTBUF+1)'(w_ppop);

  always_comb begin
    w_ppop = 1'b0;
    w_apop = 1'b0;
    if (r_state == IDLE_S) begin
      w_ppop = !w_pempty && !w_aempty && pktout_ready;
      w_apop = w_ppop;
    end else begin
      w_ppop = !w_pempty && !(r_wvld && w_tail);
    end
  end

  always_ff @(posedge clk) begin
    if (w_ppush) r_pmem[r_pwr] <= pktin_data;
    if (w_apush) r_amem[r_awr] <= action;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pwr         <= '0;
      r_prd         <= '0;
      r_pcnt        <= '0;
      r_awr         <= '0;
      r_ard         <= '0;
      r_acnt        <= '0;
      r_pktin_ready <= 1'b1;
      r_act_ovf     <= 1'b0;
    end else begin
      if (w_ppush) r_pwr <= r_pwr + D_PKTBUF'(1);
      if (w_ppop)  r_prd <= r_prd + D_PKTBUF'(1);
      r_pcnt        <= w_pcnt_nxt;
      r_pktin_ready <= (w_pcnt_nxt < c_THRESH);
      if (w_apush) r_awr <= r_awr + D_ACTBUF'(1);
      if (w_apop)  r_ard <= r_ard + D_ACTBUF'(1);
      r_acnt <= r_acnt + (D_ACTBUF+1)'(w_apush) - (D_ACTBUF+1)'(w_apop);
      if (action_valid && !w_apush) r_act_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE_S;
      r_word        <= '0;
      r_wvld        <= 1'b0;
      r_act         <= 1'b0;
      r_pktout_wr   <= 1'b0;
      r_pktout_data <= '0;
    end else begin
      r_pktout_wr <= 1'b0;
      r_wvld      <= w_ppop;
      if (w_ppop) r_word <= r_pmem[r_prd];
      case (r_state)
        IDLE_S: begin
          if (w_apop) begin
            r_act   <= r_amem[r_ard];
            r_state <= DECIDE_S;
          end
        end
        DECIDE_S: begin
          if (!r_act) begin
            r_pktout_wr   <= 1'b1;
            r_pktout_data <= r_word;
          end
          if (w_tail)     r_state <= IDLE_S;
          else if (r_act) r_state <= DISCARD_S;
          else            r_state <= FORWARD_S;
        end
        FORWARD_S: begin
          if (r_wvld) begin
            r_pktout_wr   <= 1'b1;
            r_pktout_data <= r_word;
            if (w_tail) r_state <= IDLE_S;
          end
        end
        default: begin
          if (r_wvld && w_tail) r_state <= IDLE_S;
        end
      endcase
    end
  end

`ifdef FIREWALL_FILTER_CNT_EN
  logic [31:0] r_pass_cnt, r_drop_cnt;

  // Every packet passes through DECIDE_S exactly once, so count it there.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pass_cnt <= '0;
      r_drop_cnt <= '0;
    end else if (r_state == DECIDE_S) begin
      if (r_act) r_drop_cnt <= r_drop_cnt + 32'd1;
      else       r_pass_cnt <= r_pass_cnt + 32'd1;
    end
  end

  assign pass_cnt = r_pass_cnt;
  assign drop_cnt = r_drop_cnt;
`else
  assign pass_cnt = 32'd0;
  assign drop_cnt = 32'd0;
`endif

  assign pktin_ready    = r_pktin_ready;
  assign pktout_data_wr = r_pktout_wr;
  assign pktout_data    = r_pktout_data;
  assign act_ovf        = r_act_ovf;

endmodule
`default_nettype wire

// File: tb/tb_firewall_filter.sv
`default_nettype none
// ============================================================================
// tb_firewall_filter - directed and randomized packet/action traffic compared
// against a packet-level reference model of forward/discard decisions.
// Revision: 1.0
// ============================================================================
module tb_firewall_filter;

  logic         clk = 1'b0;
  logic         reset;
  logic         pktin_data_wr;
  logic [133:0] pktin_data;
  logic         pktin_ready;
  logic         action_valid;
  logic         action;
  logic         pktout_data_wr;
  logic [133:0] pktout_data;
  logic         pktout_ready;
  logic [31:0]  pass_cnt;
  logic [31:0]  drop_cnt;
  logic         act_ovf;

  firewall_filter dut (
    .clk           (clk),
    .reset         (reset),
    .pktin_data_wr (pktin_data_wr),
    .pktin_data    (pktin_data),
    .pktin_ready   (pktin_ready),
    .action_valid  (action_valid),
    .action        (action),
    .pktout_data_wr(pktout_data_wr),
    .pktout_data   (pktout_data),
    .pktout_ready  (pktout_ready),
    .pass_cnt      (pass_cnt),
    .drop_cnt      (drop_cnt),
    .act_ovf       (act_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: packets and actions pair up in order, whole packets only.
  logic [133:0] m_words[$];
  int           m_lens[$];
  bit           m_acts[$];
  logic [133:0] exp_q[$];
  logic [31:0]  m_pass = 0;
  logic [31:0]  m_drop = 0;

  logic [133:0] got[$];
  int           got_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (reset && pktout_data_wr) begin
      got.push_back(pktout_data);
      got_cyc.push_back(cyc);
    end

  task automatic chk(input string tag, input logic [133:0] obs, input logic [133:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef FIREWALL_FILTER_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [133:0] mkword(input logic [1:0] tag);
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return {tag, r[131:0]};
  endfunction

  function automatic void resolve();
    bit           a;
    int           n;
    logic [133:0] w;
    while (m_acts.size() > 0 && m_lens.size() > 0) begin
      a = m_acts.pop_front();
      n = m_lens.pop_front();
      for (int i = 0; i < n; i++) begin
        w = m_words.pop_front();
        if (!a) exp_q.push_back(w);
      end
      if (a) m_drop = m_drop + 32'd1;
      else   m_pass = m_pass + 32'd1;
    end
  endfunction

  task automatic push_word(input logic [133:0] w);
    pktin_data_wr = 1'b1;
    pktin_data    = w;
    tick();
    pktin_data_wr = 1'b0;
  endtask

  task automatic send_pkt(input int len, input bit gaps);
    logic [1:0]   tag;
    logic [133:0] w;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1)  tag = 2'b10;
      else if (i == 0)   tag = 2'b01;
      else               tag = 2'b11;
      w = mkword(tag);
      m_words.push_back(w);
      push_word(w);
      if (gaps && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
    end
    m_lens.push_back(len);
    resolve();
  endtask

  task automatic send_act(input bit a);
    action_valid = 1'b1;
    action       = a;
    tick();
    action_valid = 1'b0;
    m_acts.push_back(a);
    resolve();
  endtask

  task automatic wait_drain();
    int t = 0;
    while (got.size() < exp_q.size() && t < 3000) begin
      tick();
      t++;
    end
    repeat (6) tick();
  endtask

  task automatic chk_stream(input string tag);
    int n;
    chk({tag, "_len"}, 134'(got.size()), 134'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_word"}, got[i], exp_q[i]);
    got.delete();
    got_cyc.delete();
    exp_q.delete();
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_wr"},    134'(pktout_data_wr), 134'(0));
    chk({tag, "_data"},  pktout_data,          134'(0));
    chk({tag, "_ready"}, 134'(pktin_ready),    134'(1));
    chk({tag, "_pass"},  134'(pass_cnt),       134'(0));
    chk({tag, "_drop"},  134'(drop_cnt),       134'(0));
    chk({tag, "_ovf"},   134'(act_ovf),        134'(0));
  endtask

  initial begin
    int           land;
    int           t;
    logic [133:0] w;
    int           nw;

    reset = 1'b0; pktin_data_wr = 1'b0; pktin_data = '0;
    action_valid = 1'b0; action = 1'b0; pktout_ready = 1'b0;
    repeat (3) tick();
    chk_idle_outputs("rst_held");
    reset = 1'b1;
    tick();
    chk_idle_outputs("rst_rel");

    // Permit path: 4-word packet, action follows
    pktout_ready = 1'b1;
    send_pkt(4, 1'b0);
    send_act(1'b0);
    wait_drain();
    if (got_cyc.size() == 4) chk("permit_consec", 134'(got_cyc[3] - got_cyc[0]), 134'(3));
    else                     chk("permit_count", 134'(got_cyc.size()), 134'(4));
    chk_stream("permit");
    chk("permit_pass", 134'(pass_cnt), 134'(cnt_exp(m_pass)));
    chk("permit_drop", 134'(drop_cnt), 134'(cnt_exp(m_drop)));

    // Deny path followed by a permitted 2-word packet
    send_pkt(3, 1'b0);
    send_act(1'b1);
    send_pkt(2, 1'b0);
    send_act(1'b0);
    wait_drain();
    chk_stream("deny");
    chk("deny_pass", 134'(pass_cnt), 134'(cnt_exp(m_pass)));
    chk("deny_drop", 134'(drop_cnt), 134'(cnt_exp(m_drop)));

    // Action waits 10 cycles ahead of a single-word packet
    send_act(1'b0);
    repeat (10) tick();
    w = mkword(2'b10);
    m_words.push_back(w);
    push_word(w);
    land = cyc;
    m_lens.push_back(1);
    resolve();
    wait_drain();
    if (got_cyc.size() == 1) chk("single_latency", 134'(got_cyc[0] - land), 134'(2));
    else                     chk("single_count", 134'(got_cyc.size()), 134'(1));
    chk_stream("single");
    chk("single_pass", 134'(pass_cnt), 134'(cnt_exp(m_pass)));

    // Randomized traffic with mid-packet gaps and random downstream readiness
    for (int p = 0; p < 14; p++) begin
      bit a_first;
      bit a;
      a_first = 1'($urandom_range(0, 1));
      a       = 1'($urandom_range(0, 1));
      pktout_ready = ($urandom_range(0, 3) != 0);
      if (a_first) send_act(a);
      send_pkt($urandom_range(1, 7), 1'b1);
      if (!a_first) send_act(a);
    end
    pktout_ready = 1'b1;
    wait_drain();
    chk_stream("random");
    chk("random_pass", 134'(pass_cnt), 134'(cnt_exp(m_pass)));
    chk("random_drop", 134'(drop_cnt), 134'(cnt_exp(m_drop)));

    // Backpressure: 10 packets of 17 words with downstream held off
    pktout_ready = 1'b0;
    for (int p = 0; p < 10; p++) send_act(1'($urandom_range(0, 1)));
    nw = 0;
    for (int p = 0; p < 10; p++) begin
      for (int i = 0; i < 17; i++) begin
        w = mkword((i == 16) ? 2'b10 : ((i == 0) ? 2'b01 : 2'b11));
        m_words.push_back(w);
        push_word(w);
        nw++;
        if (nw == 159) chk("bp_ready_159", 134'(pktin_ready), 134'(1));
        if (nw == 160) chk("bp_ready_160", 134'(pktin_ready), 134'(0));
        if (nw == 170) chk("bp_ready_170", 134'(pktin_ready), 134'(0));
      end
      m_lens.push_back(17);
    end
    repeat (5) tick();
    chk("bp_no_output", 134'(got.size()), 134'(0));
    resolve();
    pktout_ready = 1'b1;
    wait_drain();
    chk_stream("bp");
    chk("bp_ready_back", 134'(pktin_ready), 134'(1));

    // Action FIFO overflow: 17 actions with no packets
    for (int i = 0; i < 16; i++) send_act(1'($urandom_range(0, 1)));
    chk("ovf_after16", 134'(act_ovf), 134'(0));
    action_valid = 1'b1;
    action       = 1'b0;
    tick();
    action_valid = 1'b0;
    chk("ovf_after17", 134'(act_ovf), 134'(1));
    for (int i = 0; i < 17; i++) send_pkt(1, 1'b0);
    wait_drain();
    chk("ovf_extra_pending", 134'(m_lens.size()), 134'(1));
    chk_stream("ovf");
    chk("ovf_sticky", 134'(act_ovf), 134'(1));
    chk("ovf_pass", 134'(pass_cnt), 134'(cnt_exp(m_pass)));
    chk("ovf_drop", 134'(drop_cnt), 134'(cnt_exp(m_drop)));

`ifdef FIREWALL_FILTER_CNT_EN
    // Counter wrap; one permit action covers the leftover packet from above
    force dut.r_pass_cnt = 32'hFFFF_FFFF;
    tick();
    release dut.r_pass_cnt;
    m_pass = 32'hFFFF_FFFF;
    send_act(1'b0);
    wait_drain();
    chk_stream("wrap");
    chk("wrap_pass", 134'(pass_cnt), 134'(0));
    chk("wrap_model", 134'(pass_cnt), 134'(m_pass));
`endif

    // Reset in the middle of a forwarded packet
    send_act(1'b0);
    send_pkt(20, 1'b0);
    chk("midrst_started", 134'(got.size() > 0), 134'(1));
    reset = 1'b0;
    #1;
    chk_idle_outputs("midrst");
    tick();
    tick();
    reset = 1'b1;
    m_words.delete(); m_lens.delete(); m_acts.delete(); exp_q.delete();
    got.delete(); got_cyc.delete();
    m_pass = 0; m_drop = 0;
    repeat (3) tick();
    chk("midrst_no_output", 134'(got.size()), 134'(0));

    // Clean traffic after the aborted packet
    send_pkt(2, 1'b0);
    send_act(1'b0);
    send_pkt(3, 1'b0);
    send_act(1'b1);
    wait_drain();
    chk_stream("post_rst");
    chk("post_rst_pass", 134'(pass_cnt), 134'(cnt_exp(m_pass)));
    chk("post_rst_drop", 134'(drop_cnt), 134'(cnt_exp(m_drop)));

    t = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
